// File: rtl/ide_xfer_tracker.sv
// IDE bus snooper: tracks the active command and the PIO transfer position,
// and drives a registered byte-swap select for the downstream datapath.
module ide_xfer_tracker #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned WORDS_PER_SECTOR = 256,
  parameter bit          SWAP_IDLE        = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       _RESET,
  input  logic [1:0] _CS,
  input  logic [2:0] DA,
  input  logic       _DIOW,
  input  logic       _DIOR,
  input  logic [7:0] D_LO,
  output logic       SWAP,
  output logic [7:0] CMD,
  output logic       XFER_ACTIVE,
  output logic       RAW_XFER,
  output logic [7:0] WORD_CNT,
  output logic [8:0] SECT_LEFT
);

  localparam int unsigned NSTAGE = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned BUS_W  = 16;
  // Inactive bus: bus reset, strobes released, no chip select.
  localparam logic [BUS_W-1:0] BUS_IDLE  = {1'b1, 1'b1, 1'b1, 2'b11, 3'b000, 8'h00};
  localparam logic [7:0]       LAST_WORD = 8'(WORDS_PER_SECTOR - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER_SWAP = 2'd1,
    XFER_RAW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] cs;
    logic [2:0] da;
    logic [7:0] data;
  } access_t;

  logic [BUS_W-1:0] sync_q [NSTAGE];
  logic [BUS_W-1:0] bus_s;
  logic             bus_rst_s;
  logic             diow_s;
  logic             dior_s;
  logic [1:0]       cs_s;
  logic [2:0]       da_s;
  logic [7:0]       d_s;

  logic             diow_q;
  logic             dior_q;
  access_t          cap;

  logic             wr_ev;
  logic             rd_ev;
  logic             ev_scwr;
  logic             ev_cmdwr;
  logic             ev_srst;
  logic             ev_data;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       sc_shadow;
  logic [7:0]       sc_nxt;
  logic [7:0]       cmd_nxt;
  logic [7:0]       wc_nxt;
  logic [8:0]       sl_nxt;

  function automatic logic is_pio(input logic [7:0] c);
    case (c)
      8'h20, 8'h21, 8'h30, 8'h31, 8'hC4, 8'hC5: is_pio = 1'b1;
      default:                                  is_pio = 1'b0;
    endcase
  endfunction

  function automatic logic is_ident(input logic [7:0] c);
    is_ident = (c == 8'hEC) || (c == 8'hA1);
  endfunction

  // Multi-stage synchroniser on every asynchronous bus input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NSTAGE); i++) sync_q[i] <= BUS_IDLE;
    end else begin
      sync_q[0] <= {_RESET, _DIOW, _DIOR, _CS, DA, D_LO};
      for (int i = 1; i < int'(NSTAGE); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus_s     = sync_q[NSTAGE-1];
  assign bus_rst_s = bus_s[15];
  assign diow_s    = bus_s[14];
  assign dior_s    = bus_s[13];
  assign cs_s      = bus_s[12:11];
  assign da_s      = bus_s[10:8];
  assign d_s       = bus_s[7:0];

  // Capture tracks the bus while a strobe is held, so the release edge sees
  // the address/data that were valid just before the strobe went high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      diow_q <= 1'b1;
      dior_q <= 1'b1;
      cap    <= '{cs: 2'b11, da: 3'd0, data: 8'h00};
    end else begin
      diow_q <= diow_s;
      dior_q <= dior_s;
      if (!diow_s || !dior_s) cap <= '{cs: cs_s, da: da_s, data: d_s};
    end
  end

  // Access decode; a simultaneous read release is folded into the write.
  always_comb begin
    wr_ev    = diow_s & ~diow_q;
    rd_ev    = dior_s & ~dior_q & ~wr_ev;
    ev_scwr  = wr_ev & (cap.cs == 2'b10) & (cap.da == 3'd2);
    ev_cmdwr = wr_ev & (cap.cs == 2'b10) & (cap.da == 3'd7);
    ev_srst  = wr_ev & (cap.cs == 2'b01) & (cap.da == 3'd6) & cap.data[2];
    ev_data  = (wr_ev | rd_ev) & (cap.cs == 2'b10) & (cap.da == 3'd0);
  end

  // Next-state and counter update; bus reset outranks every access.
  always_comb begin
    state_nxt = state;
    sc_nxt    = sc_shadow;
    cmd_nxt   = CMD;
    wc_nxt    = WORD_CNT;
    sl_nxt    = SECT_LEFT;
    if (!bus_rst_s || ev_srst) begin
      state_nxt = IDLE;
      wc_nxt    = 8'd0;
      sl_nxt    = 9'd0;
    end else if (ev_cmdwr) begin
      cmd_nxt = cap.data;
      wc_nxt  = 8'd0;
      if (is_pio(cap.data)) begin
        state_nxt = XFER_SWAP;
        sl_nxt    = (sc_shadow == 8'd0) ? 9'd256 : {1'b0, sc_shadow};
      end else if (is_ident(cap.data)) begin
        state_nxt = XFER_RAW;
        sl_nxt    = 9'd1;
      end else begin
        state_nxt = IDLE;
        sl_nxt    = 9'd0;
      end
    end else if (ev_scwr) begin
      sc_nxt = cap.data;
    end else if (ev_data && (state != IDLE)) begin
      if (WORD_CNT == LAST_WORD) begin
        wc_nxt = 8'd0;
        sl_nxt = SECT_LEFT - 9'd1;
        if (SECT_LEFT == 9'd1) state_nxt = IDLE;
      end else begin
        wc_nxt = WORD_CNT + 8'd1;
      end
    end
  end

  // State register with outputs derived from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      sc_shadow   <= 8'h01;
      CMD         <= 8'h00;
      WORD_CNT    <= 8'd0;
      SECT_LEFT   <= 9'd0;
      XFER_ACTIVE <= 1'b0;
      RAW_XFER    <= 1'b0;
      SWAP        <= SWAP_IDLE;
    end else begin
      state       <= state_nxt;
      sc_shadow   <= sc_nxt;
      CMD         <= cmd_nxt;
      WORD_CNT    <= wc_nxt;
      SECT_LEFT   <= sl_nxt;
      XFER_ACTIVE <= (state_nxt != IDLE);
      RAW_XFER    <= (state_nxt == XFER_RAW);
      case (state_nxt)
        XFER_SWAP: SWAP <= 1'b1;
        XFER_RAW:  SWAP <= 1'b0;
        default:   SWAP <= SWAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_xfer_tracker.sv
// Scoreboard bench for ide_xfer_tracker: stimulus queues expected states with
// the cycle they must appear; a monitor compares them on the falling edge.
module tb_ide_xfer_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_rst_n = 1'b1;
  logic [1:0] cs_n = 2'b11;
  logic [2:0] da = 3'd0;
  logic       diow_n = 1'b1;
  logic       dior_n = 1'b1;
  logic [7:0] d_lo = 8'h00;

  logic       swap_o [2];
  logic [7:0] cmd_o  [2];
  logic       act_o  [2];
  logic       raw_o  [2];
  logic [7:0] wc_o   [2];
  logic [8:0] sl_o   [2];

  ide_xfer_tracker u_dut (
    .CLK(clk), .RST(rst), ._RESET(bus_rst_n), ._CS(cs_n), .DA(da),
    ._DIOW(diow_n), ._DIOR(dior_n), .D_LO(d_lo),
    .SWAP(swap_o[0]), .CMD(cmd_o[0]), .XFER_ACTIVE(act_o[0]),
    .RAW_XFER(raw_o[0]), .WORD_CNT(wc_o[0]), .SECT_LEFT(sl_o[0])
  );

  // Short sectors so a full 256-sector transfer fits in a quick run.
  ide_xfer_tracker #(.WORDS_PER_SECTOR(4)) u_dut4 (
    .CLK(clk), .RST(rst), ._RESET(bus_rst_n), ._CS(cs_n), .DA(da),
    ._DIOW(diow_n), ._DIOR(dior_n), .D_LO(d_lo),
    .SWAP(swap_o[1]), .CMD(cmd_o[1]), .XFER_ACTIVE(act_o[1]),
    .RAW_XFER(raw_o[1]), .WORD_CNT(wc_o[1]), .SECT_LEFT(sl_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         dut;
    string      name;
    logic       swap;
    logic [7:0] cmd;
    logic       act;
    logic       raw;
    logic [7:0] wc;
    logic [8:0] sl;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_st(input int due, input int dut, input string name,
                           input logic sw, input logic [7:0] c, input logic act,
                           input logic raw, input logic [7:0] wc, input logic [8:0] sl);
    exp_t e;
    e.due = due; e.dut = dut; e.name = name;
    e.swap = sw; e.cmd = c; e.act = act; e.raw = raw; e.wc = wc; e.sl = sl;
    sbq.push_back(e);
  endtask

  // Monitor: pop every expectation that falls due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL %s: check due at cycle %0d missed, now %0d", e.name, e.due, cyc);
        end else if (swap_o[e.dut] !== e.swap || cmd_o[e.dut] !== e.cmd ||
                     act_o[e.dut] !== e.act || raw_o[e.dut] !== e.raw ||
                     wc_o[e.dut] !== e.wc || sl_o[e.dut] !== e.sl) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got swap=%b cmd=%h act=%b raw=%b wc=%0d sl=%0d, want swap=%b cmd=%h act=%b raw=%b wc=%0d sl=%0d",
                   e.name, e.dut, cyc, swap_o[e.dut], cmd_o[e.dut], act_o[e.dut],
                   raw_o[e.dut], wc_o[e.dut], sl_o[e.dut],
                   e.swap, e.cmd, e.act, e.raw, e.wc, e.sl);
        end
      end
    end
  end

  // One bus cycle: strobe(s) low for one clock, released, then high for one.
  // rel is the cycle of the release; effects are due at rel+3.
  task automatic access(input logic wr, input logic rd, input logic [1:0] cs,
                        input logic [2:0] a, input logic [7:0] d, output int rel);
    cs_n = cs; da = a; d_lo = d;
    if (wr) diow_n = 1'b0;
    if (rd) dior_n = 1'b0;
    @(negedge clk);
    diow_n = 1'b1; dior_n = 1'b1;
    rel = cyc;
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d, output int rel);
    access(1'b1, 1'b0, 2'b10, a, d, rel);
  endtask

  task automatic data_burst(input logic wr, input int n, output int rel);
    for (int i = 0; i < n; i++) access(wr, ~wr, 2'b10, 3'd0, 8'(i), rel);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    int c;
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_st(cyc + 1, 0, "reset", 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 9'd0);
    expect_st(cyc + 1, 1, "reset", 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 9'd0);
    idle(2);

    // Two-sector PIO read, swapped.
    reg_wr(3'd2, 8'h02, r);
    reg_wr(3'd7, 8'h20, r);
    expect_st(r + 3, 0, "pio_start", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd2);
    data_burst(1'b0, 256, r);
    expect_st(r + 3, 0, "sector1_done", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd1);
    data_burst(1'b0, 255, r);
    expect_st(r + 3, 0, "read_511", 1'b1, 8'h20, 1'b1, 1'b0, 8'd255, 9'd1);
    data_burst(1'b0, 1, r);
    expect_st(r + 3, 0, "read_512_idle", 1'b1, 8'h20, 1'b0, 1'b0, 8'd0, 9'd0);
    idle(4);

    // Identify: raw single sector, then a stray read in IDLE.
    reg_wr(3'd7, 8'hEC, r);
    expect_st(r + 3, 0, "ident_start", 1'b0, 8'hEC, 1'b1, 1'b1, 8'd0, 9'd1);
    data_burst(1'b0, 255, r);
    expect_st(r + 3, 0, "ident_255", 1'b0, 8'hEC, 1'b1, 1'b1, 8'd255, 9'd1);
    data_burst(1'b0, 1, r);
    expect_st(r + 3, 0, "ident_done", 1'b1, 8'hEC, 1'b0, 1'b0, 8'd0, 9'd0);
    data_burst(1'b0, 1, r);
    expect_st(r + 3, 0, "data_in_idle", 1'b1, 8'hEC, 1'b0, 1'b0, 8'd0, 9'd0);
    idle(4);

    // Sector count 0 means 256 sectors; the 4-word instance completes them all.
    reg_wr(3'd2, 8'h00, r);
    reg_wr(3'd7, 8'h30, r);
    expect_st(r + 3, 0, "sc0_start", 1'b1, 8'h30, 1'b1, 1'b0, 8'd0, 9'd256);
    expect_st(r + 3, 1, "sc0_start", 1'b1, 8'h30, 1'b1, 1'b0, 8'd0, 9'd256);
    data_burst(1'b1, 1023, r);
    expect_st(r + 3, 1, "write_1023", 1'b1, 8'h30, 1'b1, 1'b0, 8'd3, 9'd1);
    data_burst(1'b1, 1, r);
    expect_st(r + 3, 1, "write_1024_idle", 1'b1, 8'h30, 1'b0, 1'b0, 8'd0, 9'd0);
    expect_st(r + 3, 0, "write_1024", 1'b1, 8'h30, 1'b1, 1'b0, 8'd0, 9'd252);

    // Aborts: command rewrite, device-control SRST, bus reset.
    data_burst(1'b1, 100, r);
    expect_st(r + 3, 0, "mid_wc100", 1'b1, 8'h30, 1'b1, 1'b0, 8'd100, 9'd252);
    reg_wr(3'd7, 8'hEC, r);
    expect_st(r + 3, 0, "abort_to_raw", 1'b0, 8'hEC, 1'b1, 1'b1, 8'd0, 9'd1);
    reg_wr(3'd7, 8'h20, r);
    expect_st(r + 3, 0, "restart_256", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd256);
    data_burst(1'b1, 100, r);
    access(1'b1, 1'b0, 2'b01, 3'd6, 8'h02, r);
    expect_st(r + 3, 0, "dc_no_srst", 1'b1, 8'h20, 1'b1, 1'b0, 8'd100, 9'd256);
    access(1'b1, 1'b0, 2'b01, 3'd6, 8'h04, r);
    expect_st(r + 3, 0, "dc_srst", 1'b1, 8'h20, 1'b0, 1'b0, 8'd0, 9'd0);
    reg_wr(3'd7, 8'h21, r);
    data_burst(1'b1, 5, r);
    expect_st(r + 3, 0, "pre_bus_reset", 1'b1, 8'h21, 1'b1, 1'b0, 8'd5, 9'd256);
    idle(4);
    bus_rst_n = 1'b0;
    c = cyc;
    expect_st(c + 2, 0, "bus_reset_lat", 1'b1, 8'h21, 1'b1, 1'b0, 8'd5, 9'd256);
    expect_st(c + 3, 0, "bus_reset", 1'b1, 8'h21, 1'b0, 1'b0, 8'd0, 9'd0);
    idle(3);
    bus_rst_n = 1'b1;
    idle(4);
    reg_wr(3'd7, 8'h20, r);
    expect_st(r + 3, 0, "sc_kept", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd256);

    // Unknown command, non-SC register writes, exact latency.
    reg_wr(3'd7, 8'hEF, r);
    expect_st(r + 3, 0, "unknown_cmd", 1'b1, 8'hEF, 1'b0, 1'b0, 8'd0, 9'd0);
    reg_wr(3'd2, 8'h05, r);
    for (int a = 1; a <= 6; a++) if (a != 2) reg_wr(3'(a), 8'h77, r);
    reg_wr(3'd7, 8'hEC, r);
    expect_st(r + 2, 0, "latency_before", 1'b1, 8'hEF, 1'b0, 1'b0, 8'd0, 9'd0);
    expect_st(r + 3, 0, "latency_after", 1'b0, 8'hEC, 1'b1, 1'b1, 8'd0, 9'd1);
    reg_wr(3'd7, 8'h20, r);
    expect_st(r + 3, 0, "sc_shadow_5", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd5);

    // Simultaneous read/write release counts as the write.
    data_burst(1'b1, 3, r);
    expect_st(r + 3, 0, "pre_dual", 1'b1, 8'h20, 1'b1, 1'b0, 8'd3, 9'd5);
    access(1'b1, 1'b1, 2'b10, 3'd7, 8'h21, r);
    expect_st(r + 3, 0, "dual_strobe", 1'b1, 8'h21, 1'b1, 1'b0, 8'd0, 9'd5);
    data_burst(1'b0, 2, r);
    expect_st(r + 3, 0, "pre_rst", 1'b1, 8'h21, 1'b1, 1'b0, 8'd2, 9'd5);
    idle(4);

    // Core reset mid-transfer, then the shadow count is back to 1.
    rst = 1'b1;
    expect_st(cyc + 1, 0, "rst_mid", 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 9'd0);
    expect_st(cyc + 1, 1, "rst_mid", 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 9'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    reg_wr(3'd7, 8'h20, r);
    expect_st(r + 3, 0, "sc_reset_val", 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 9'd1);

    t = 0;
    while (sbq.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
